// File: rtl/jlp_flash_sd.sv
`default_nettype none
// jlp_flash_sd: sector bridge between the hps_io SD block port and the JLP flash RAM.
// Loads the save image into flash RAM on mount; writes the region back on save_req.
module jlp_flash_sd #(
  parameter int SECTORS = 16,
  parameter int AW      = $clog2(SECTORS) + 9
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          img_mounted,
  input  logic [63:0]   img_size,
  input  logic          img_readonly,
  output logic [31:0]   sd_lba,
  output logic          sd_rd,
  output logic          sd_wr,
  input  logic          sd_ack,
  input  logic [8:0]    sd_buff_addr,
  input  logic [7:0]    sd_buff_dout,
  input  logic          sd_buff_wr,
  output logic [7:0]    sd_buff_din,
  output logic [AW-1:0] fl_addr,
  output logic [7:0]    fl_wdata,
  output logic          fl_we,
  input  logic [7:0]    fl_rdata,
  input  logic          save_req,
  output logic          loaded,
  output logic          busy
);

  localparam int            IW    = 9;
  localparam logic [IW-1:0] SEC_N = IW'(SECTORS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_XFER = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_XFER = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] nsec_q, nsec_d;
  logic          writable_q, writable_d;
  logic          loaded_q, loaded_d;
  logic          save_pend_q, save_pend_d;
  logic          mnt_pend_q, mnt_pend_d;
  logic          mnt_ro_q, mnt_ro_d;
  logic [54:0]   mnt_sec_q, mnt_sec_d;
  logic          ack_q;
  logic          fl_we_q, fl_we_d;
  logic [AW-1:0] fl_waddr_q, fl_waddr_d;
  logic [7:0]    fl_wdata_q, fl_wdata_d;

  logic          is_busy;
  logic          ack_fall;
  logic          save_set;
  logic          mnt_any;
  logic [54:0]   m_sec;
  logic          m_ro;
  logic [IW-1:0] m_nsec;
  logic [IW-1:0] idx_inc;
  logic [AW-1:0] xfer_addr;
  logic          unused_size_lsb;

  assign is_busy         = (state_q != S_IDLE);
  assign ack_fall        = ack_q & ~sd_ack;
  assign idx_inc         = idx_q + 1'b1;
  assign xfer_addr       = AW'({idx_q, sd_buff_addr});
  assign unused_size_lsb = ^img_size[8:0];

  // A live mount pulse takes precedence over one latched while busy.
  assign m_sec   = img_mounted ? img_size[63:9] : mnt_sec_q;
  assign m_ro    = img_mounted ? img_readonly : mnt_ro_q;
  assign m_nsec  = (m_sec >= 55'(SECTORS)) ? SEC_N : m_sec[8:0];
  assign mnt_any = img_mounted | mnt_pend_q;

  assign save_set = save_req & ~img_mounted & writable_q & (loaded_q | is_busy);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    nsec_d      = nsec_q;
    writable_d  = writable_q;
    loaded_d    = loaded_q;
    save_pend_d = save_pend_q;
    mnt_pend_d  = mnt_pend_q;
    mnt_ro_d    = mnt_ro_q;
    mnt_sec_d   = mnt_sec_q;
    fl_we_d     = 1'b0;
    fl_waddr_d  = fl_waddr_q;
    fl_wdata_d  = fl_wdata_q;

    if (img_mounted && is_busy) begin
      mnt_pend_d = 1'b1;
      mnt_sec_d  = img_size[63:9];
      mnt_ro_d   = img_readonly;
    end

    case (state_q)
      S_IDLE: begin
        if (mnt_any) begin
          mnt_pend_d  = 1'b0;
          save_pend_d = 1'b0;
          loaded_d    = 1'b0;
          idx_d       = '0;
          if (m_nsec == '0) begin
            nsec_d     = '0;
            writable_d = 1'b0;
          end else begin
            nsec_d     = m_nsec;
            writable_d = ~m_ro;
            state_d    = S_RD_REQ;
          end
        end else if (save_pend_q) begin
          save_pend_d = 1'b0;
          idx_d       = '0;
          state_d     = S_WR_REQ;
        end
      end
      S_RD_REQ: begin
        if (sd_ack) state_d = S_RD_XFER;
      end
      S_RD_XFER: begin
        if (sd_ack && sd_buff_wr) begin
          fl_we_d    = 1'b1;
          fl_waddr_d = xfer_addr;
          fl_wdata_d = sd_buff_dout;
        end
        if (ack_fall) begin
          idx_d = idx_inc;
          if (mnt_any) begin
            state_d = S_IDLE;
          end else if (idx_inc == nsec_q) begin
            loaded_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_RD_REQ;
          end
        end
      end
      S_WR_REQ: begin
        if (sd_ack) state_d = S_WR_XFER;
      end
      S_WR_XFER: begin
        if (ack_fall) begin
          idx_d   = idx_inc;
          state_d = (mnt_any || idx_inc == nsec_q) ? S_IDLE : S_WR_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (save_set)    save_pend_d = 1'b1;
    if (img_mounted) save_pend_d = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      nsec_q      <= '0;
      writable_q  <= 1'b0;
      loaded_q    <= 1'b0;
      save_pend_q <= 1'b0;
      mnt_pend_q  <= 1'b0;
      mnt_ro_q    <= 1'b0;
      mnt_sec_q   <= '0;
      ack_q       <= 1'b0;
      fl_we_q     <= 1'b0;
      fl_waddr_q  <= '0;
      fl_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      nsec_q      <= nsec_d;
      writable_q  <= writable_d;
      loaded_q    <= loaded_d;
      save_pend_q <= save_pend_d;
      mnt_pend_q  <= mnt_pend_d;
      mnt_ro_q    <= mnt_ro_d;
      mnt_sec_q   <= mnt_sec_d;
      ack_q       <= sd_ack;
      fl_we_q     <= fl_we_d;
      fl_waddr_q  <= fl_waddr_d;
      fl_wdata_q  <= fl_wdata_d;
    end
  end

  // Save reads are addressed combinationally so fl_rdata lands one cycle after sd_buff_addr.
  assign fl_addr     = fl_we_q ? fl_waddr_q : ((state_q == S_WR_XFER) ? xfer_addr : '0);
  assign fl_we       = fl_we_q;
  assign fl_wdata    = fl_wdata_q;
  assign sd_buff_din = fl_rdata;
  assign sd_lba      = {23'd0, idx_q};
  assign sd_rd       = (state_q == S_RD_REQ);
  assign sd_wr       = (state_q == S_WR_REQ);
  assign loaded      = loaded_q;
  assign busy        = is_busy;

endmodule
`default_nettype wire

// File: tb/tb_jlp_flash_sd.sv
`default_nettype none
// tb_jlp_flash_sd: hps_io host model plus flash RAM model around jlp_flash_sd.
module tb_jlp_flash_sd;
  localparam int SECTORS = 16;
  localparam int AW      = 13;
  localparam int NB      = SECTORS * 512;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          img_mounted;
  logic [63:0]   img_size;
  logic          img_readonly;
  logic [31:0]   sd_lba;
  logic          sd_rd, sd_wr;
  logic          sd_ack;
  logic [8:0]    sd_buff_addr;
  logic [7:0]    sd_buff_dout;
  logic          sd_buff_wr;
  logic [7:0]    sd_buff_din;
  logic [AW-1:0] fl_addr;
  logic [7:0]    fl_wdata;
  logic          fl_we;
  logic [7:0]    fl_rdata = 8'h00;
  logic          save_req;
  logic          loaded, busy;

  always #5 clk_sys = ~clk_sys;

  jlp_flash_sd #(.SECTORS(SECTORS)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .img_mounted(img_mounted), .img_size(img_size), .img_readonly(img_readonly),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din),
    .fl_addr(fl_addr), .fl_wdata(fl_wdata), .fl_we(fl_we), .fl_rdata(fl_rdata),
    .save_req(save_req), .loaded(loaded), .busy(busy)
  );

  logic [7:0] ram  [NB];
  logic [7:0] img  [NB];
  logic [7:0] wimg [NB];
  bit         log_kind [$];
  int         log_lba  [$];
  bit         host_kind;
  int         host_lba;
  bit         host_xfer;
  int         n_pass  = 0;
  int         n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  // Flash RAM: registered read, write strobe from the bridge.
  initial begin
    forever begin
      @(posedge clk_sys);
      fl_rdata = ram[fl_addr];
      if (fl_we) ram[fl_addr] = fl_wdata;
    end
  end

  // hps_io host: answers each sd_rd/sd_wr with a 512-byte transfer, logs requests.
  initial begin
    sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0;
    host_kind = 1'b0; host_lba = 0; host_xfer = 1'b0;
    forever begin
      tick();
      if (reset_n && (sd_rd || sd_wr)) begin
        host_kind = sd_wr;
        host_lba  = int'(sd_lba) % SECTORS;
        log_kind.push_back(sd_wr);
        log_lba.push_back(int'(sd_lba));
        tick(); tick();
        if (reset_n) begin
          sd_ack = 1'b1;
          tick();
          if (reset_n) chk("req_drop_after_ack", {62'd0, sd_rd, sd_wr}, 64'd0);
          host_xfer = 1'b1;
          for (int i = 0; i < 512 && reset_n; i++) begin
            sd_buff_addr = 9'(i);
            if (!host_kind) begin
              sd_buff_dout = img[host_lba*512 + i];
              sd_buff_wr   = 1'b1;
              tick();
              sd_buff_wr   = 1'b0;
              if (i % 128 == 127) tick();
            end else begin
              tick();
              wimg[host_lba*512 + i] = sd_buff_din;
            end
          end
        end
        sd_buff_wr = 1'b0;
        tick();
        sd_ack    = 1'b0;
        host_xfer = 1'b0;
      end
    end
  end

  // Per-cycle compare: flash writes one cycle after each host data strobe; idle quiet.
  initial begin
    bit            pw;
    logic [AW-1:0] pa;
    logic [7:0]    pd;
    pw = 1'b0; pa = '0; pd = '0;
    forever begin
      @(negedge clk_sys);
      if (reset_n) begin
        chk("fl_we_timing", {63'd0, fl_we}, {63'd0, pw});
        if (pw) begin
          chk("fl_addr_wr", 64'(fl_addr), 64'(pa));
          chk("fl_wdata_wr", 64'(fl_wdata), 64'(pd));
        end
        if (!busy)
          chk("idle_quiet", {50'd0, sd_rd, sd_wr, fl_we, fl_addr}, 64'd0);
        if (host_xfer) chk("lba_stable", 64'(sd_lba), 64'(host_lba));
      end
      pw = reset_n && sd_ack && sd_buff_wr && host_xfer && !host_kind;
      pa = AW'(host_lba*512 + int'(sd_buff_addr));
      pd = sd_buff_dout;
    end
  end

  task automatic mount(input logic [63:0] sz, input logic ro);
    img_size = sz; img_readonly = ro; img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
  endtask

  task automatic pulse_save();
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 20000) begin tick(); n++; end
    chk(nm, {63'd0, busy}, 64'd0);
  endtask

  task automatic wait_log(input int cnt);
    int n = 0;
    while (log_lba.size() < cnt && n < 20000) begin tick(); n++; end
    chk("wait_log_timeout", 64'(log_lba.size() >= cnt), 64'd1);
  endtask

  task automatic check_seq(input bit kind, input int off, input int cnt);
    for (int j = 0; j < cnt; j++) begin
      if (off + j < log_lba.size()) begin
        chk(kind ? "log_wr_kind" : "log_rd_kind", 64'(log_kind[off+j]), 64'(kind));
        chk("log_lba", 64'(log_lba[off+j]), 64'(j));
      end
    end
  endtask

  task automatic clear_log();
    log_kind.delete();
    log_lba.delete();
  endtask

  task automatic check_ram_img(input int s0, input int s1);
    for (int s = s0; s <= s1; s++) begin
      int bad = 0;
      for (int i = 0; i < 512; i++) if (ram[s*512+i] !== img[s*512+i]) bad++;
      chk("ram_sector_loaded", 64'(bad), 64'd0);
    end
  endtask

  initial begin
    bit seen;
    for (int a = 0; a < NB; a++) begin
      ram[a] = 8'h00; wimg[a] = 8'h00; img[a] = 8'(a*7 + 3);
    end
    reset_n = 1'b0; img_mounted = 1'b0; img_size = '0; img_readonly = 1'b0; save_req = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_sd_lba", 64'(sd_lba), 64'd0);
    chk("rst_rd_wr", {62'd0, sd_rd, sd_wr}, 64'd0);
    chk("rst_fl", {42'd0, fl_we, fl_wdata, fl_addr}, 64'd0);
    chk("rst_buff_din", 64'(sd_buff_din), 64'd0);
    chk("rst_loaded_busy", {62'd0, loaded, busy}, 64'd0);

    // Full 16-sector load.
    clear_log();
    mount(64'd8192, 1'b0);
    chk("rd_next_cycle", {63'd0, sd_rd}, 64'd1);
    wait_idle("load16_timeout");
    chk("load16_loaded", {63'd0, loaded}, 64'd1);
    chk("load16_count", 64'(log_lba.size()), 64'd16);
    check_seq(1'b0, 0, 16);
    check_ram_img(0, 15);
    chk("pin_ram0", 64'(ram[0]), 64'h03);
    chk("pin_ram513", 64'(ram[513]), 64'h0A);

    // Save of a preset pattern.
    for (int a = 0; a < NB; a++) ram[a] = 8'(a) ^ 8'h5A;
    clear_log();
    pulse_save();
    tick();
    chk("save_started", {63'd0, busy}, 64'd1);
    wait_idle("save16_timeout");
    chk("save16_count", 64'(log_lba.size()), 64'd16);
    check_seq(1'b1, 0, 16);
    for (int s = 0; s < 16; s++) begin
      int bad = 0;
      for (int i = 0; i < 512; i++) if (wimg[s*512+i] !== (8'(s*512+i) ^ 8'h5A)) bad++;
      chk("save_sector_data", 64'(bad), 64'd0);
    end
    chk("pin_wimg513", 64'(wimg[513]), 64'h5B);

    // Short image: 1500 bytes -> 2 sectors; rest of RAM untouched.
    for (int a = 0; a < NB; a++) begin ram[a] = 8'hEE; wimg[a] = 8'h00; end
    clear_log();
    mount(64'd1500, 1'b0);
    wait_idle("load2_timeout");
    chk("load2_loaded", {63'd0, loaded}, 64'd1);
    chk("load2_count", 64'(log_lba.size()), 64'd2);
    check_seq(1'b0, 0, 2);
    check_ram_img(0, 1);
    begin
      int bad = 0;
      for (int a = 1024; a < NB; a++) if (ram[a] !== 8'hEE) bad++;
      chk("load2_untouched", 64'(bad), 64'd0);
    end
    clear_log();
    pulse_save();
    tick();
    wait_idle("save2_timeout");
    chk("save2_count", 64'(log_lba.size()), 64'd2);
    check_seq(1'b1, 0, 2);
    chk("pin_wimg1", 64'(wimg[1]), 64'h0A);
    chk("pin_wimg1023", 64'(wimg[1023]), 64'(img[1023]));
    chk("save2_no_sector2", 64'(wimg[1024]), 64'h00);

    // Read-only image: save_req ignored.
    clear_log();
    mount(64'd8192, 1'b1);
    wait_idle("load_ro_timeout");
    chk("load_ro_count", 64'(log_lba.size()), 64'd16);
    clear_log();
    pulse_save();
    seen = 1'b0;
    repeat (100) begin tick(); if (sd_wr || busy) seen = 1'b1; end
    chk("ro_no_save", {63'd0, seen}, 64'd0);
    chk("ro_log_empty", 64'(log_lba.size()), 64'd0);

    // save_req during load of lba 5 -> full load then full save.
    clear_log();
    mount(64'd8192, 1'b0);
    wait_log(6);
    pulse_save();
    wait_idle("load_then_save_timeout");
    chk("mid_load_loaded", {63'd0, loaded}, 64'd1);
    tick();
    chk("queued_save_started", {63'd0, busy}, 64'd1);
    wait_idle("queued_save_timeout");
    chk("load_save_count", 64'(log_lba.size()), 64'd32);
    check_seq(1'b0, 0, 16);
    check_seq(1'b1, 16, 16);

    // Unmount.
    clear_log();
    mount(64'd0, 1'b0);
    chk("unmount_loaded", {63'd0, loaded}, 64'd0);
    seen = 1'b0;
    repeat (50) begin tick(); if (sd_rd || busy) seen = 1'b1; end
    chk("unmount_quiet", {63'd0, seen}, 64'd0);
    chk("unmount_log", 64'(log_lba.size()), 64'd0);

    // Reset in the middle of reading lba 3.
    clear_log();
    mount(64'd8192, 1'b0);
    wait_log(4);
    repeat (60) tick();
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_rd_wr", {62'd0, sd_rd, sd_wr}, 64'd0);
    chk("rst_async_fl_we", {63'd0, fl_we}, 64'd0);
    chk("rst_async_busy", {63'd0, busy}, 64'd0);
    chk("rst_async_loaded", {63'd0, loaded}, 64'd0);
    repeat (4) tick();
    reset_n = 1'b1;
    repeat (4) tick();
    clear_log();
    pulse_save();
    seen = 1'b0;
    repeat (100) begin tick(); if (sd_rd || sd_wr || busy) seen = 1'b1; end
    chk("post_reset_quiet", {63'd0, seen}, 64'd0);
    chk("post_reset_log", 64'(log_lba.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
